ram_burst_reader: RTL
=====================

Name: ram_burst_reader

Overview:
- Read-side initiator for the 1-write/1-read byte-masked RAM macro used by the VexRiscv SMP memories.
- Accepts a burst read command on a valid/ready stream and drives the RAM read port (rd_en/rd_addr).
- Captures the registered rd_data and returns it as a back-pressured response stream.
- Sits between cache/DMA logic and the RAM, on the same clock as the RAM read port.

Parameters:
- ADDR_WIDTH, 10, RAM word-address width; address space is 2**ADDR_WIDTH words.
- DATA_WIDTH, 32, RAM read data width in bits; must equal 8 × mask width of the RAM.
- LEN_WIDTH, 8, burst length field width; a burst is cmd_len+1 beats.

Ports:
- clk  in  1  single clock; also drives the RAM rd_clk.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  burst command valid.
- cmd_ready  out  1  burst command accepted when cmd_valid && cmd_ready.
- cmd_addr  in  ADDR_WIDTH  first word address.
- cmd_len  in  LEN_WIDTH  beats minus one.
- rsp_valid  out  1  response beat valid.
- rsp_ready  in  1  consumer accepts beat.
- rsp_data  out  DATA_WIDTH  read word.
- rsp_last  out  1  final beat of the burst.
- rd_en  out  1  RAM read enable.
- rd_addr  out  ADDR_WIDTH  RAM read address.
- rd_data  in  DATA_WIDTH  RAM read data, valid the cycle after rd_en; held while rd_en low.
- busy  out  1  high from command accept until the last beat is popped.

Behaviour:
- Reset (async, active-high) values:
  - state=IDLE; cmd_ready=1.
  - rsp_valid=0, rsp_last=0, rsp_data=0.
  - rd_en=0, rd_addr=0, busy=0.
  - FIFO empty; in-flight flag=0.
- Reset mid-burst discards all in-flight and buffered beats. No beat is emitted after reset deasserts until a new command is accepted.
- FSM states:
  - IDLE: cmd_ready=1. On accept, latch addr into the address counter and len into the remaining counter, then go to RUN.
  - RUN: cmd_ready=0. Issue reads under the credit rule below. When the read with remaining==0 is issued, go to DRAIN.
  - DRAIN: cmd_ready=0. Wait until the FIFO is empty and no read is in flight, then go to IDLE.
- Credit rule:
  - rd_en is asserted in a RUN cycle only if occ + inflight − pop ≤ 1.
  - occ = FIFO entries (0..2); inflight = read issued last cycle; pop = rsp_valid && rsp_ready.
  - The FIFO therefore never overflows.
- Per issue: rd_addr = counter; the counter increments modulo 2**ADDR_WIDTH (1023 → 0 wraps silently); remaining decrements.
- Capture: in the cycle after rd_en, push {rd_data, last_flag} into the 2-entry FIFO. last_flag = the issued beat was remaining==0.
- Response stream:
  - rsp_* presents the FIFO head.
  - rsp_valid/rsp_data/rsp_last stay stable while rsp_valid && !rsp_ready.
  - Beats are returned in address order.
- Latency: accept at cycle T → rd_en at T+1 → rsp_valid at T+2.
- Throughput: with rsp_ready held high, one beat per cycle.
- Simultaneous FIFO push and pop in one cycle is legal, including at occ=2.
- cmd_len=0 gives a single beat with rsp_last=1.
- Maximum burst is 2**LEN_WIDTH beats and may wrap the address.
- busy = state != IDLE.
- The next command can be accepted the cycle after DRAIN returns to IDLE.

Decomposition:
- Shared package: state enum {IDLE, RUN, DRAIN}; a beat struct {data, last}.
- One natural sub-module: ram_burst_reader_fifo2, a 2-entry synchronous FIFO with push/pop/occ outputs.
- The ram_burst_reader top instantiates it and holds the FSM and counters.

Test Plan:
- Backing RAM preloaded with word[i]=i; cmd addr=0x010, len=3, rsp_ready=1:
  - rsp 0x10,0x11,0x12,0x13 on consecutive cycles, first rsp_valid at accept+2.
  - rsp_last only on 0x13; busy drops after it.
- Same command with rsp_ready toggling 1,0,0,1,0,1…:
  - All four words in order; no beat lost or duplicated; rsp_data stable while stalled.
  - rd_en never asserted when occ+inflight−pop>1.
- Wrap: addr=0x3FE, len=3 → rd_addr sequence 0x3FE,0x3FF,0x000,0x001; data matches.
- Single beat: len=0, addr=0x055 → exactly one rsp, data 0x55, rsp_last=1; cmd_ready back to 1 two cycles after rsp pop.
- Reset asserted mid-burst (addr=0, len=15, after 5 beats issued, rsp_ready=0):
  - All outputs return to reset values immediately.
  - After release, no stale rsp_valid.
  - A new command addr=0x100, len=1 returns 0x100,0x101.
- Back-to-back: cmd_valid held high with two queued commands (0x020/len 1, 0x040/len 1):
  - Second accepted only after the first's last beat drains.
  - Output 0x20,0x21(last),0x40,0x41(last).

Source files
------------

// File: rtl/ram_burst_reader_pkg.sv
// Shared types and helpers for the RAM burst read initiator.
package ram_burst_reader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   // Issue only if the beat can still land in the 2-entry FIFO next cycle.
   function automatic logic credit_ok(input logic [1:0] occ,
                                      input logic       inflight,
                                      input logic       pop);
      return ({1'b0, occ} + {2'b00, inflight}) <= (3'd1 + {2'b00, pop});
   endfunction

endpackage

// File: rtl/ram_burst_reader_fifo2.sv
// 2-entry fall-through FIFO: an empty FIFO presents a same-cycle push at its head.
module ram_burst_reader_fifo2 #(
   parameter int W = 33
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_push,
   input  logic [W-1:0] i_push_dat,
   input  logic         i_pop,
   output logic         o_vld,
   output logic [W-1:0] o_head_dat,
   output logic [1:0]   o_occ
);

   logic [W-1:0] r_mem [2];
   logic         r_wp;
   logic         r_rp;
   logic [1:0]   r_occ;
   logic         w_empty;
   logic         w_wr;
   logic         w_rd;

   assign w_empty    = (r_occ == 2'd0);
   assign o_vld      = !w_empty || i_push;
   assign o_head_dat = w_empty ? i_push_dat : r_mem[r_rp];
   assign o_occ      = r_occ;

   // A push consumed in the same cycle while empty never touches storage.
   assign w_wr = i_push && !(w_empty && i_pop);
   assign w_rd = i_pop && !w_empty;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wp     <= 1'b0;
         r_rp     <= 1'b0;
         r_occ    <= 2'd0;
      end else begin
         if (w_wr) begin
            r_mem[r_wp] <= i_push_dat;
            r_wp        <= ~r_wp;
         end
         if (w_rd) begin
            r_rp <= ~r_rp;
         end
         r_occ <= r_occ + {1'b0, w_wr} - {1'b0, w_rd};
      end
   end

endmodule

// File: rtl/ram_burst_reader.sv
// Burst read initiator: turns one address/length command into RAM reads and a
// back-pressured response stream; reads are credit-limited to the 2-entry FIFO.
module ram_burst_reader
   import ram_burst_reader_pkg::*;
#(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32,
   parameter int LEN_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [LEN_WIDTH-1:0]  cmd_len,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic                  rsp_last,
   output logic                  rd_en,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [DATA_WIDTH-1:0] rd_data,
   output logic                  busy
);

   state_t                r_state;
   state_t                w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [LEN_WIDTH-1:0]  r_rem;
   logic                  r_inflight;
   logic                  r_inflight_last;
   logic                  w_issue;
   logic                  w_accept;
   logic                  w_pop;
   logic                  w_fifo_vld;
   logic [DATA_WIDTH:0]   w_head;
   logic [1:0]            w_occ;

   ram_burst_reader_fifo2 #(
      .W (DATA_WIDTH + 1)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .i_push     (r_inflight),
      .i_push_dat ({rd_data, r_inflight_last}),
      .i_pop      (w_pop),
      .o_vld      (w_fifo_vld),
      .o_head_dat (w_head),
      .o_occ      (w_occ)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_issue     = 1'b0;
      cmd_ready   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               w_state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            w_issue = credit_ok(w_occ, r_inflight, w_pop);
            if (w_issue && (r_rem == '0)) begin
               w_state_nxt = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if ((w_occ == 2'd0) && !r_inflight) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign w_accept  = cmd_valid && cmd_ready;
   assign w_pop     = w_fifo_vld && rsp_ready;
   assign rd_en     = w_issue;
   assign rd_addr   = r_addr;
   assign busy      = (r_state != ST_IDLE);
   assign rsp_valid = w_fifo_vld;
   assign rsp_data  = w_fifo_vld ? w_head[DATA_WIDTH:1] : '0;
   assign rsp_last  = w_fifo_vld && w_head[0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state         <= ST_IDLE;
         r_addr          <= '0;
         r_rem           <= '0;
         r_inflight      <= 1'b0;
         r_inflight_last <= 1'b0;
      end else begin
         r_state         <= w_state_nxt;
         r_inflight      <= w_issue;
         r_inflight_last <= w_issue && (r_rem == '0);
         if (w_accept) begin
            r_addr <= cmd_addr;
            r_rem  <= cmd_len;
         end else if (w_issue) begin
            // Address wraps silently at the top of the RAM.
            r_addr <= r_addr + 1'b1;
            r_rem  <= r_rem - 1'b1;
         end
      end
   end

endmodule
